alu_seq_unit: RTL and testbench

Operand/writeback sequencer that sits directly upstream and downstream of the 16-bit ALU. It accepts one command at a time over a valid/ready handshake and reads two operands from an 8-entry register file. It drives the ALU's A/B/Sel inputs from registered values, captures Out_0/Out_1 and the carry/zero flags, and writes the results back to the register file and a flag register. MUL results are written back as two words.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_regfile.sv | 43 ++++
 rtl/alu_seq_unit.sv | 138 +++++++++++++
 tb/tb_alu_seq_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/writeback sequencer: opcodes,
// the sequencer state encoding and the datapath width.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_SHL = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WB    = 2'd2,
    WB_HI = 2'd3
  } state_t;

  // Opcodes above AND are reserved.
  function automatic logic op_illegal(input logic [3:0] op);
    return (op > OP_AND);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: 2**RF_AW x DATA_W entries, one write port shared between the
// sequencer writeback and the host, two operand read ports and a host read port.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int RF_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seq_we,
  input  logic [RF_AW-1:0]  seq_addr,
  input  logic [DATA_W-1:0] seq_data,
  input  logic              host_we,
  input  logic [RF_AW-1:0]  host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic [RF_AW-1:0]  ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [RF_AW-1:0]  ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic [RF_AW-1:0]  ra3,
  output logic [DATA_W-1:0] rd3
);

  localparam int DEPTH = 2 ** RF_AW;

  logic [DATA_W-1:0] regs [DEPTH];

  // Sequencer writeback wins; host writes are only offered while idle anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (seq_we) begin
      regs[seq_addr] <= seq_data;
    end else if (host_we) begin
      regs[host_addr] <= host_data;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
  assign rd3 = regs[ra3];

endmodule

// File: rtl/alu_seq_unit.sv
// Operand/writeback sequencer around the external 16-bit ALU: one command at a
// time, operands from the register file, results and flags written back.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int RF_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [RF_AW-1:0]  cmd_rd,
  input  logic [RF_AW-1:0]  cmd_rs1,
  input  logic [RF_AW-1:0]  cmd_rs2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out1,
  input  logic [DATA_W-1:0] alu_out0,
  input  logic              alu_c,
  input  logic              alu_z,
  output logic              done_valid,
  output logic              done_err,
  output logic [DATA_W-1:0] done_data,
  output logic              c_flag,
  output logic              z_flag,
  input  logic              hw_en,
  input  logic [RF_AW-1:0]  hw_addr,
  input  logic [DATA_W-1:0] hw_data,
  input  logic [RF_AW-1:0]  hr_addr,
  output logic [DATA_W-1:0] hr_data
);

  state_t            state, state_nx;
  logic [RF_AW-1:0]  rd_p0;
  logic              mul_p0, err_p0;
  logic [DATA_W-1:0] res_lo_p1, res_hi_p1;
  logic              res_c_p1, res_z_p1;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              accept, host_we, seq_we, flag_we;
  logic [RF_AW-1:0]  seq_addr;
  logic [DATA_W-1:0] seq_data;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign host_we   = hw_en && cmd_ready;
  assign done_data = res_lo_p1;

  alu_regfile #(.RF_AW(RF_AW)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .seq_we    (seq_we),
    .seq_addr  (seq_addr),
    .seq_data  (seq_data),
    .host_we   (host_we),
    .host_addr (hw_addr),
    .host_data (hw_data),
    .ra1       (cmd_rs1),
    .rd1       (rs1_data),
    .ra2       (cmd_rs2),
    .rd2       (rs2_data),
    .ra3       (hr_addr),
    .rd3       (hr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    done_valid = 1'b0;
    done_err   = 1'b0;
    seq_we     = 1'b0;
    flag_we    = 1'b0;
    seq_addr   = rd_p0;
    seq_data   = res_lo_p1;
    case (state)
      IDLE:  if (accept) state_nx = EXEC;
      EXEC:  state_nx = WB;
      WB: begin
        seq_we     = !err_p0;
        flag_we    = !err_p0;
        done_valid = !mul_p0;
        done_err   = !mul_p0 && err_p0;
        state_nx   = mul_p0 ? WB_HI : IDLE;
      end
      WB_HI: begin
        done_valid = 1'b1;
        seq_we     = 1'b1;
        seq_addr   = rd_p0 + RF_AW'(1);
        seq_data   = res_hi_p1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: operand/command latch at accept. Stage p1: ALU result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rd_p0     <= '0;
      mul_p0    <= 1'b0;
      err_p0    <= 1'b0;
      res_lo_p1 <= '0;
      res_hi_p1 <= '0;
      res_c_p1  <= 1'b0;
      res_z_p1  <= 1'b0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= rs1_data;
        alu_b   <= rs2_data;
        alu_sel <= cmd_op;
        rd_p0   <= cmd_rd;
        mul_p0  <= (cmd_op == OP_MUL);
        err_p0  <= op_illegal(cmd_op);
      end
      if (state == EXEC) begin
        res_lo_p1 <= alu_out0;
        res_hi_p1 <= alu_out1;
        res_c_p1  <= alu_c;
        res_z_p1  <= alu_z;
      end
      if (flag_we) begin
        c_flag <= res_c_p1;
        z_flag <= res_z_p1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: behavioural ALU on the DUT's ALU port, directed
// scenarios followed by randomized commands against a register-file model.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out1, alu_out0;
  logic        alu_c, alu_z;
  logic        done_valid, done_err;
  logic [15:0] done_data;
  logic        c_flag, z_flag;
  logic        hw_en;
  logic [2:0]  hw_addr, hr_addr;
  logic [15:0] hw_data, hr_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] rf_m [8];
  logic        c_m, z_m;

  alu_seq_unit #(.RF_AW(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out1(alu_out1), .alu_out0(alu_out0), .alu_c(alu_c), .alu_z(alu_z),
    .done_valid(done_valid), .done_err(done_err), .done_data(done_data),
    .c_flag(c_flag), .z_flag(z_flag),
    .hw_en(hw_en), .hw_addr(hw_addr), .hw_data(hw_data),
    .hr_addr(hr_addr), .hr_data(hr_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {out1, out0, c, z}.
  function automatic logic [33:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] hi, lo;
    logic        c;
    hi = 16'h0; lo = 16'h0; c = 1'b0;
    case (op)
      4'd0: begin p = 32'(a) + 32'(b); lo = p[15:0]; c = p[16]; end
      4'd1: begin lo = a - b; c = (a < b); end
      4'd2: begin p = 32'(a) * 32'(b); hi = p[31:16]; lo = p[15:0]; end
      4'd3: lo = a << b[3:0];
      4'd4: lo = a >> b[3:0];
      4'd5: lo = a | b;
      4'd6: lo = a ^ b;
      4'd7: lo = ~a;
      4'd8: lo = a & b;
      default: begin lo = 16'hDEAD; hi = 16'hBAD0; c = 1'b1; end
    endcase
    return {hi, lo, c, (lo == 16'h0)};
  endfunction

  always_comb {alu_out1, alu_out0, alu_c, alu_z} = alu_fn(alu_sel, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 8; i++) begin
      hr_addr = 3'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(hr_data), 32'(rf_m[i]));
    end
    chk({tag, "_c"}, 32'(c_flag), 32'(c_m));
    chk({tag, "_z"}, 32'(z_flag), 32'(z_m));
  endtask

  task automatic host_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    hw_en = 1'b1; hw_addr = a; hw_data = d;
    @(negedge clk);
    hw_en = 1'b0;
    rf_m[a] = d;
  endtask

  // One command; optional host write on the accept edge (coll) and a host
  // write attempt while busy (busy_hw) that must be ignored.
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input bit coll, input logic [2:0] caddr, input logic [15:0] cdata,
                         input bit busy_hw);
    logic [33:0] r;
    bit err, mul;
    int lat;
    r   = alu_fn(op, rf_m[rs1], rf_m[rs2]);
    err = (op > 4'd8);
    mul = (op == 4'd2);
    lat = mul ? 3 : 2;
    @(negedge clk);
    chk({tag, "_ready_in"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    if (coll) begin hw_en = 1'b1; hw_addr = caddr; hw_data = cdata; end
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = 1'b0; hw_en = 1'b0;
        cmd_op = 4'($urandom); cmd_rs1 = 3'($urandom); cmd_rs2 = 3'($urandom);
        if (busy_hw) begin hw_en = 1'b1; hw_addr = 3'($urandom); hw_data = 16'($urandom); end
      end
      if (k == 2) hw_en = 1'b0;
      chk($sformatf("%s_dv_k%0d", tag, k), 32'(done_valid), (k == lat) ? 32'd1 : 32'd0);
      if (k == lat) begin
        chk({tag, "_data"}, 32'(done_data), 32'(r[17:2]));
        chk({tag, "_err"}, 32'(done_err), 32'(err));
      end
      chk($sformatf("%s_rdy_k%0d", tag, k), 32'(cmd_ready), (k == lat + 1) ? 32'd1 : 32'd0);
    end
    if (coll) rf_m[caddr] = cdata;
    if (!err) begin
      rf_m[rd] = r[17:2];
      c_m = r[1];
      z_m = r[0];
      if (mul) rf_m[3'(rd + 3'd1)] = r[33:18];
    end
    check_rf(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    hw_en = 1'b0; hw_addr = '0; hw_data = '0; hr_addr = '0;
    for (int i = 0; i < 8; i++) rf_m[i] = 16'h0;
    c_m = 1'b0; z_m = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_dv", 32'(done_valid), 32'd0);
    chk("rst_derr", 32'(done_err), 32'd0);
    chk("rst_ddata", 32'(done_data), 32'd0);
    check_rf("rst");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_release_ready", 32'(cmd_ready), 32'd1);

    // ADD
    host_write(3'd1, 16'h0005);
    host_write(3'd2, 16'h0003);
    run_cmd("add", 4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0);
    chk("add_r3", 32'(rf_m[3]), 32'h0008);

    // SUB with borrow, then zero result
    host_write(3'd1, 16'h0003);
    host_write(3'd2, 16'h0005);
    run_cmd("sub_borrow", 4'd1, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0);
    run_cmd("sub_zero", 4'd1, 3'd4, 3'd1, 3'd1, 1'b0, 3'd0, 16'h0, 1'b0);

    // MUL with rd wrap into r0
    host_write(3'd1, 16'h1234);
    host_write(3'd2, 16'h0100);
    run_cmd("mul_wrap", 4'd2, 3'd7, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0);

    // Illegal opcode with flags preset to 1/1
    host_write(3'd5, 16'hFFFF);
    host_write(3'd6, 16'h0001);
    run_cmd("flag_set", 4'd0, 3'd5, 3'd5, 3'd6, 1'b0, 3'd0, 16'h0, 1'b0);
    host_write(3'd2, 16'hBEEF);
    run_cmd("illegal", 4'hC, 3'd2, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0, 1'b1);

    // Dependency chain and host write colliding with accept
    host_write(3'd1, 16'h0001);
    run_cmd("dep1", 4'd0, 3'd1, 3'd1, 3'd1, 1'b0, 3'd0, 16'h0, 1'b0);
    run_cmd("dep2", 4'd0, 3'd1, 3'd1, 3'd1, 1'b0, 3'd0, 16'h0, 1'b0);
    run_cmd("coll", 4'd0, 3'd3, 3'd1, 3'd1, 1'b1, 3'd1, 16'h0100, 1'b0);

    // Randomized commands
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      if ($urandom_range(0, 4) == 0) host_write(3'($urandom), 16'($urandom));
      run_cmd($sformatf("rnd%0d", n), op, 3'($urandom), 3'($urandom), 3'($urandom),
              ($urandom_range(0, 3) == 0), 3'($urandom), 16'($urandom),
              ($urandom_range(0, 2) == 0));
    end

    // Reset during the WB cycle of a MUL
    host_write(3'd1, 16'h0003);
    host_write(3'd2, 16'h0007);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd2; cmd_rd = 3'd4; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rstmul_dv_exec", 32'(done_valid), 32'd0);
    @(negedge clk);
    chk("rstmul_dv_wb", 32'(done_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstmul_dv_abort", 32'(done_valid), 32'd0);
    chk("rstmul_ready_in_rst", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 8; i++) rf_m[i] = 16'h0;
    c_m = 1'b0; z_m = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rstmul_dv_hold%0d", k), 32'(done_valid), 32'd0);
      chk($sformatf("rstmul_rdy_hold%0d", k), 32'(cmd_ready), 32'd0);
    end
    check_rf("rstmul");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rstmul_ready_after", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rstmul_dv_after%0d", k), 32'(done_valid), 32'd0);
    end
    check_rf("rstmul_after");

    // Recovery: a command works normally after reset
    run_cmd("post_rst", 4'd5, 3'd0, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
